// File: rtl/wide_tcdm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wide_tcdm_port_arbiter
// Brief    : Round-robin arbiter with bounded burst hold sharing one wide TCDM
//            superbank port; routes the 1-cycle-late response to its owner.
// Revision : 1.0
// ============================================================================
module wide_tcdm_port_arbiter #(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned MaxHold   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*AddrWidth-1:0]   add_i,
    input  logic [NumReq-1:0]             wen_i,
    input  logic [NumReq*DataWidth-1:0]   wdata_i,
    input  logic [NumReq*DataWidth/8-1:0] be_i,
    output logic [NumReq-1:0]             gnt_o,
    output logic [NumReq-1:0]             rvalid_o,
    output logic [DataWidth-1:0]          rdata_o,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [AddrWidth-1:0]          mem_add_o,
    output logic                          mem_wen_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    output logic [DataWidth/8-1:0]        mem_be_o,
    input  logic [DataWidth-1:0]          mem_rdata_i
);

    localparam int unsigned c_be_w  = DataWidth / 8;
    localparam int unsigned c_idx_w = $clog2(NumReq);
    localparam int unsigned c_cnt_w = $clog2(MaxHold + 1);
    localparam logic [c_cnt_w-1:0] c_max_hold = c_cnt_w'(MaxHold);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NumReq - 1);

    logic [c_idx_w-1:0] r_rr_ptr;
    logic [c_idx_w-1:0] r_owner;
    logic [c_idx_w-1:0] r_rsp_idx;
    logic [c_cnt_w-1:0] r_hold_cnt;
    logic               r_locked;
    logic               r_rsp_valid;

    logic [c_idx_w-1:0] w_rr_winner;
    logic [c_idx_w-1:0] w_winner;
    logic [c_idx_w-1:0] w_rr_next;
    logic [c_cnt_w-1:0] w_hold_next;
    logic [NumReq-1:0]  w_owner_mask;
    logic               w_others;
    logic               w_hold_ok;
    logic               w_hs;

    // First active requester at or after the round-robin pointer, circularly.
    always_comb begin : p_rr_search
        logic [c_idx_w:0] k;
        logic             found;
        w_rr_winner = r_rr_ptr;
        found       = 1'b0;
        k           = '0;
        for (int i = 0; i < NumReq; i++) begin
            k = {1'b0, r_rr_ptr} + (c_idx_w+1)'(i);
            if (k >= (c_idx_w+1)'(NumReq)) begin
                k = k - (c_idx_w+1)'(NumReq);
            end
            if (!found && req_i[k[c_idx_w-1:0]]) begin
                found       = 1'b1;
                w_rr_winner = k[c_idx_w-1:0];
            end
        end
    end

    assign w_owner_mask = NumReq'(1) << r_owner;
    assign w_others     = |(req_i & ~w_owner_mask);
    // The hold limit only bites when somebody else is waiting.
    assign w_hold_ok    = req_i[r_owner] && ((r_hold_cnt < c_max_hold) || !w_others);
    assign w_winner     = (r_locked || w_hold_ok) ? r_owner : w_rr_winner;

    assign mem_req_o   = |req_i;
    assign w_hs        = mem_req_o & mem_gnt_i;
    assign mem_add_o   = add_i[w_winner*AddrWidth +: AddrWidth];
    assign mem_wen_o   = wen_i[w_winner];
    assign mem_wdata_o = wdata_i[w_winner*DataWidth +: DataWidth];
    assign mem_be_o    = be_i[w_winner*c_be_w +: c_be_w];

    assign gnt_o    = w_hs ? (NumReq'(1) << w_winner) : '0;
    assign rvalid_o = r_rsp_valid ? (NumReq'(1) << r_rsp_idx) : '0;
    assign rdata_o  = mem_rdata_i;

    // r_rsp_idx doubles as the last requester that completed a handshake, so a
    // stalled lock by a new requester does not inherit the previous burst count.
    assign w_hold_next = (w_winner != r_rsp_idx) ? c_cnt_w'(1) :
                         (r_hold_cnt == c_max_hold) ? r_hold_cnt : r_hold_cnt + c_cnt_w'(1);
    assign w_rr_next   = (w_winner == c_last_idx) ? '0 : w_winner + c_idx_w'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_rsp_idx   <= '0;
            r_hold_cnt  <= '0;
            r_locked    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_hs;
            if (w_hs) begin
                r_rsp_idx  <= w_winner;
                r_owner    <= w_winner;
                r_locked   <= 1'b0;
                r_hold_cnt <= w_hold_next;
                r_rr_ptr   <= w_rr_next;
            end else if (mem_req_o) begin
                r_locked <= 1'b1;
                r_owner  <= w_winner;
            end
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
    a_rvalid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
    a_locked_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (mem_req_o && !mem_gnt_i) |=> (req_i[r_owner] && $stable(mem_add_o) && $stable(mem_wen_o)
                                       && $stable(mem_wdata_o) && $stable(mem_be_o)));

endmodule
`default_nettype wire

// File: tb/tb_wide_tcdm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_tcdm_port_arbiter
// Brief    : Vector table, directed corner sequences and randomized model check
// Revision : 1.0
// ============================================================================
module tb_wide_tcdm_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int HOLD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, mem_req, mem_gnt, mem_wen;
    logic [N-1:0]    req, wen, gnt, rvalid;
    logic [N*AW-1:0] add;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_add;
    logic [BW-1:0]   mem_be;

    logic            b_rst, b_mem_req, b_mem_gnt, b_mem_wen;
    logic [N-1:0]    b_req, b_wen, b_gnt, b_rvalid;
    logic [N*AW-1:0] b_add;
    logic [N*DW-1:0] b_wdata;
    logic [N*BW-1:0] b_be;
    logic [DW-1:0]   b_rdata, b_mem_wdata, b_mem_rdata;
    logic [AW-1:0]   b_mem_add;
    logic [BW-1:0]   b_mem_be;

    wide_tcdm_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxHold(HOLD)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
        .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req),
        .mem_gnt_i(mem_gnt), .mem_add_o(mem_add), .mem_wen_o(mem_wen),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata));

    wide_tcdm_port_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxHold(1)) u_dut_rr (
        .clk_i(clk), .rst_i(b_rst), .req_i(b_req), .add_i(b_add), .wen_i(b_wen), .wdata_i(b_wdata),
        .be_i(b_be), .gnt_o(b_gnt), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .mem_req_o(b_mem_req),
        .mem_gnt_i(b_mem_gnt), .mem_add_o(b_mem_add), .mem_wen_o(b_mem_wen),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] rq;
        logic       mg;
        logic [2:0] exp_gnt;
        logic [2:0] exp_rv;
    } vec_t;
    vec_t vec[$];

    function automatic void add_row(logic r, logic [2:0] rq, logic mg, logic [2:0] g, logic [2:0] rv);
        vec_t v;
        v.rst = r; v.rq = rq; v.mg = mg; v.exp_gnt = g; v.exp_rv = rv;
        vec.push_back(v);
    endfunction

    // Reference model: last requester to complete a handshake, its burst length,
    // the round-robin start point, a pending lock and the pending response.
    int m_last, m_cnt, m_rr, m_lock_owner, m_pend_idx;
    bit m_locked, m_pend;

    function automatic void model_reset();
        m_last = 0; m_cnt = 0; m_rr = 0; m_lock_owner = 0;
        m_locked = 0; m_pend = 0; m_pend_idx = 0;
    endfunction

    function automatic int model_winner();
        bit others = 0;
        if (m_locked) return m_lock_owner;
        for (int i = 0; i < N; i++) if (req[i] && i != m_last) others = 1;
        if (req[m_last] && (m_cnt < HOLD || !others)) return m_last;
        for (int k = 0; k < N; k++) if (req[(m_rr + k) % N]) return (m_rr + k) % N;
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] pend;
        logic [2:0]   exp_gnt, exp_rv;
        int           w;
        bit           hs;

        rst = 1; req = '0; wen = '0; add = '0; wdata = '0; be = '0; mem_gnt = 0; mem_rdata = '0;
        b_rst = 1; b_req = '0; b_wen = '0; b_add = '0; b_wdata = '0; b_be = '0; b_mem_gnt = 0; b_mem_rdata = '0;
        for (int i = 0; i < N; i++) begin
            add[i*AW +: AW]   = 32'h1000 + 32'(i) * 32'h100;
            wdata[i*DW +: DW] = {32'hD0D0_0000 + 32'(i), 32'h1234_5678};
            be[i*BW +: BW]    = 8'hFF;
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_gnt_idle", gnt, 0);
        next_cycle();
        rst = 0; b_rst = 0;

        // Single requester streaming, then MaxHold burst alternation after reset.
        for (int i = 0; i < 8; i++) add_row(0, 3'b001, 1, 3'b001, (i == 0) ? 3'b000 : 3'b001);
        add_row(0, 3'b000, 0, 3'b000, 3'b001);
        add_row(1, 3'b000, 0, 3'b000, 3'b000);
        for (int i = 0; i < 10; i++) begin
            exp_gnt = (i >= 4 && i < 8) ? 3'b010 : 3'b001;
            exp_rv  = (i == 0) ? 3'b000 : ((i >= 5 && i < 9) ? 3'b010 : 3'b001);
            add_row(0, 3'b011, 1, exp_gnt, exp_rv);
        end
        for (int r = 0; r < vec.size(); r++) begin
            rst = vec[r].rst; req = vec[r].rq; mem_gnt = vec[r].mg;
            @(negedge clk);
            chk("tbl_gnt", gnt, vec[r].exp_gnt);
            chk("tbl_rvalid", rvalid, vec[r].exp_rv);
            chk("tbl_mem_req", mem_req, |vec[r].rq);
            next_cycle();
        end

        // Stall/lock: winner and payload frozen until the memory grants.
        rst = 1; req = '0; mem_gnt = 0;
        add[1*AW +: AW] = 32'h40;
        next_cycle();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            req = 3'b001; mem_gnt = 0;
            @(negedge clk);
            chk("stall_add", mem_add, 32'h1000);
            chk("stall_gnt", gnt, 0);
            next_cycle();
        end
        req = 3'b011;
        @(negedge clk);
        chk("stall_late_req_add", mem_add, 32'h1000);
        chk("stall_late_req_gnt", gnt, 0);
        next_cycle();
        mem_gnt = 1;
        @(negedge clk);
        chk("stall_release_gnt", gnt, 3'b001);
        chk("stall_release_add", mem_add, 32'h1000);
        next_cycle();
        // Requester 2 locks while rr points at 1; requester 1 arriving must not steal it.
        req = 3'b100; mem_gnt = 0;
        @(negedge clk);
        chk("lock2_add", mem_add, 32'h1200);
        chk("lock2_rvalid", rvalid, 3'b001);
        next_cycle();
        req = 3'b110;
        @(negedge clk);
        chk("lock2_hold_add", mem_add, 32'h1200);
        chk("lock2_hold_gnt", gnt, 0);
        next_cycle();
        mem_gnt = 1;
        @(negedge clk);
        chk("lock2_gnt", gnt, 3'b100);
        next_cycle();
        // Read routing for requester 1.
        req = 3'b010;
        @(negedge clk);
        chk("rd_gnt", gnt, 3'b010);
        chk("rd_add", mem_add, 32'h40);
        chk("rd_wen", mem_wen, 0);
        next_cycle();
        req = 3'b000; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        chk("rd_rvalid", rvalid, 3'b010);
        chk("rd_rdata", rdata, 64'hA5A5_A5A5_A5A5_A5A5);
        next_cycle();
        // Reset sampled on the same edge as a handshake drops the response.
        req = 3'b010; mem_gnt = 1; rst = 1;
        @(negedge clk);
        chk("rst_hs_gnt", gnt, 3'b010);
        next_cycle();
        rst = 0; req = 3'b111;
        @(negedge clk);
        chk("rst_drop_rvalid", rvalid, 0);
        chk("rst_rr_cleared_gnt", gnt, 3'b001);
        next_cycle();
        req = '0;

        // MaxHold=1, three requesters: strict rotation with pointer wrap.
        b_req = 3'b111; b_mem_gnt = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_wrap_gnt", b_gnt, 3'b001 << (i % 3));
            chk("rr_wrap_rvalid", b_rvalid, (i == 0) ? 3'b000 : (3'b001 << ((i + 2) % 3)));
            next_cycle();
        end
        b_req = '0; b_mem_gnt = 0;

        // Randomized traffic against the reference model.
        rst = 1; mem_gnt = 0;
        next_cycle();
        rst = 0;
        model_reset();
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    add[i*AW +: AW]   = $urandom;
                    wen[i]            = 1'($urandom_range(0, 1));
                    wdata[i*DW +: DW] = {$urandom, $urandom};
                    be[i*BW +: BW]    = 8'($urandom);
                end
            end
            req = pend;
            mem_gnt = ($urandom_range(0, 99) < 70);
            mem_rdata = {$urandom, $urandom};
            rst = ($urandom_range(0, 79) == 0);
            @(negedge clk);
            w = model_winner();
            hs = (|req) && mem_gnt;
            exp_gnt = hs ? (3'b001 << w) : 3'b000;
            exp_rv  = m_pend ? (3'b001 << m_pend_idx) : 3'b000;
            chk("rnd_gnt", gnt, exp_gnt);
            chk("rnd_rvalid", rvalid, exp_rv);
            chk("rnd_mem_req", mem_req, |req);
            if (|req) begin
                chk("rnd_mem_add", mem_add, add[w*AW +: AW]);
                chk("rnd_mem_wen", mem_wen, wen[w]);
                chk("rnd_mem_wdata", mem_wdata, wdata[w*DW +: DW]);
                chk("rnd_mem_be", mem_be, be[w*BW +: BW]);
            end
            m_pend = hs; m_pend_idx = w;
            if (hs) begin
                m_cnt = (w == m_last) ? ((m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1) : 1;
                m_last = w; m_rr = (w + 1) % N; m_locked = 0;
                pend[w] = 1'b0;
            end else if (|req) begin
                m_locked = 1; m_lock_owner = w;
            end
            if (rst) begin
                model_reset();
                pend = '0;
            end
            next_cycle();
        end
        rst = 0; req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
